// File: rtl/fetch_sequencer_if.sv
// Handshake and status bundle between the fetch sequencer and the core/memory/debug logic.
// The master side is the sequencer; the slave side is the core/memory/debug environment.
interface fetch_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 MEM_RDY;
    logic                 EXT_BUSY;
    logic                 INHIBIT_INC;
    logic                 DEBUG_HALT_REQ;
    logic                 DEBUG_STEP;
    logic                 DEBUG_RUN;
    logic                 FETCH;
    logic                 MEM_REQ;
    logic                 EXECUTE;
    logic                 COMMIT;
    logic                 PC_INC;
    logic                 HALTED;
    logic [2:0]           PHASE;
    logic [CNT_WIDTH-1:0] INSTR_COUNT;

    modport master (
        input  MEM_RDY, EXT_BUSY, INHIBIT_INC, DEBUG_HALT_REQ, DEBUG_STEP, DEBUG_RUN,
        output FETCH, MEM_REQ, EXECUTE, COMMIT, PC_INC, HALTED, PHASE, INSTR_COUNT
    );

    modport slave (
        output MEM_RDY, EXT_BUSY, INHIBIT_INC, DEBUG_HALT_REQ, DEBUG_STEP, DEBUG_RUN,
        input  FETCH, MEM_REQ, EXECUTE, COMMIT, PC_INC, HALTED, PHASE, INSTR_COUNT
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction phase sequencer: IDLE/FETCH/WAIT/EXECUTE/COMMIT/HALT with debug halt,
// single-step and resume at instruction boundaries, plus a retired-instruction counter.
module fetch_sequencer #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_e               state_q, state_d;
    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic [3:0]           wait_dec_s;
    logic                 halt_pending_q, halt_pending_d;
    logic                 step_flag_q, step_flag_d;
    logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
    logic                 fetch_q, fetch_d;
    logic                 execute_q, execute_d;
    logic                 commit_q, commit_d;
    logic                 halted_q, halted_d;
    logic [2:0]           phase_q, phase_d;

    // Next-state, wait counter, debug flags and retire counter.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        halt_pending_d = halt_pending_q;
        step_flag_d    = step_flag_q;
        instr_count_d  = instr_count_q;
        wait_dec_s     = (wait_cnt_q == 4'd0) ? 4'd0 : (wait_cnt_q - 4'd1);

        if ((state_q != ST_HALT) && bus.DEBUG_HALT_REQ) begin
            halt_pending_d = 1'b1;
        end else begin
            halt_pending_d = halt_pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.DEBUG_HALT_REQ) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                wait_cnt_d = WAIT_LOAD;
                if ((WAIT_LOAD == 4'd0) && bus.MEM_RDY) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The decremented value gates the exit, so WAIT_STATES=N yields N WAIT cycles.
                wait_cnt_d = wait_dec_s;
                if ((wait_dec_s == 4'd0) && bus.MEM_RDY) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_EXECUTE: begin
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (!bus.EXT_BUSY) begin
                    instr_count_d = instr_count_q + CNT_WIDTH'(1);
                    if (halt_pending_d || step_flag_q) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_HALT: begin
                if (bus.DEBUG_HALT_REQ) begin
                    state_d = ST_HALT;
                end else if (bus.DEBUG_RUN) begin
                    state_d     = ST_FETCH;
                    step_flag_d = 1'b0;
                end else if (bus.DEBUG_STEP) begin
                    state_d     = ST_FETCH;
                    step_flag_d = 1'b1;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_HALT) && (state_q != ST_HALT)) begin
            halt_pending_d = 1'b0;
            step_flag_d    = 1'b0;
        end else begin
            halt_pending_d = halt_pending_d;
            step_flag_d    = step_flag_d;
        end
    end

    // Output decode from the next state so every output strobe comes straight off a flop.
    always_comb begin
        fetch_d   = (state_d == ST_FETCH) || (state_d == ST_WAIT);
        execute_d = (state_d == ST_EXECUTE);
        commit_d  = (state_d == ST_COMMIT);
        halted_d  = (state_d == ST_HALT);
        phase_d   = state_d;
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= 4'd0;
            halt_pending_q <= 1'b0;
            step_flag_q    <= 1'b0;
            instr_count_q  <= '0;
            fetch_q        <= 1'b0;
            execute_q      <= 1'b0;
            commit_q       <= 1'b0;
            halted_q       <= 1'b0;
            phase_q        <= 3'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            halt_pending_q <= halt_pending_d;
            step_flag_q    <= step_flag_d;
            instr_count_q  <= instr_count_d;
            fetch_q        <= fetch_d;
            execute_q      <= execute_d;
            commit_q       <= commit_d;
            halted_q       <= halted_d;
            phase_q        <= phase_d;
        end
    end

    assign bus.FETCH       = fetch_q;
    assign bus.MEM_REQ     = fetch_q;
    assign bus.EXECUTE     = execute_q;
    assign bus.COMMIT      = commit_q;
    assign bus.HALTED      = halted_q;
    assign bus.PHASE       = phase_q;
    assign bus.INSTR_COUNT = instr_count_q;
    // PC_INC is the one output allowed to follow EXT_BUSY/INHIBIT_INC within the cycle.
    assign bus.PC_INC      = commit_q && !bus.EXT_BUSY && !bus.INHIBIT_INC;
endmodule
